multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle successor to the single-cycle main decoder for the MIPS datapath. It sequences each instruction over 3–5 states instead of decoding it in one cycle. It also waits on a memory-ready handshake with a bounded timeout, and owns the N status flag used by `baln`. It sits between the instruction register's opcode field and the shared multi-cycle datapath: PC, IR, MDR, A/B, ALUOut and the register file.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 means memory states wait for `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.
- `WAIT_LIMIT`, default 16: maximum cycles spent in one memory state before abort. Must be ≥ 1.
- `WAIT_W`, default $clog2(WAIT_LIMIT+1): width of the wait counter.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset; **asynchronous and active-low**.
- `opcode`  in  6  IR[31:26].
- `nsignal`  in  1  ALU result sign bit for the current cycle.
- `mem_ready`  in  1  memory has completed the current read or write.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `alu_src_a`  out  1 each  datapath strobes and selects.
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = immediate shifted left by 2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct, 11 = or.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = A (rs).
- `reg_dst`  out  2  00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg`  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- `nsignal_q`  out  1  registered N flag.
- `illegal`  out  1  one-cycle pulse when an undecoded opcode is seen.
- `mem_timeout`  out  1  one-cycle pulse when a memory state aborts.
- `state_o`  out  4  current state, for debug.

## Operation
- Recognised opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - ori 001101
  - jrsal 010001 (jump to rs, link PC+4 into $31)
  - baln 011001 (if N is set: branch and link)
- The R-type funct field, including jmnor, is handled by ALU control. It is not decoded here.
- All outputs are Moore, decoded from state. Exceptions: gating by `mem_ready` and `nsignal_q` as noted below. Any output not listed for a state is 0.
- States and outputs:
  - FETCH: mem_read, iord=0, src_a=0, src_b=01, alu_op=00, pc_source=00. When ready: ir_write and pc_write, then go to DECODE.
  - DECODE: src_a=0, src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - lw / sw → MEMADDR
    - R-type → EXEC
    - beq → BEQ
    - ori → ORIEX
    - jrsal → JRSAL
    - baln → BALN
    - anything else → FETCH, with `illegal` pulsed.
  - MEMADDR: src_a=1, src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_read, iord=1. When ready, go to MEMWB.
  - MEMWB: reg_write, reg_dst=00, mem_to_reg=01. Go to FETCH.
  - MEMWR: mem_write, iord=1. When ready, go to FETCH.
  - EXEC: src_a=1, src_b=00, alu_op=10. Go to RWB.
  - RWB: reg_write, reg_dst=01, mem_to_reg=00. Go to FETCH.
  - BEQ: src_a=1, src_b=00, alu_op=01, pc_write_cond, pc_source=01. Go to FETCH.
  - ORIEX: src_a=1, src_b=10, alu_op=11. Go to ORIWB.
  - ORIWB: reg_write, reg_dst=00, mem_to_reg=00. Go to FETCH.
  - JRSAL: pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10. Go to FETCH.
  - BALN: pc_write = reg_write = nsignal_q, pc_source=01, reg_dst=10, mem_to_reg=10. Go to FETCH.
- N flag: `nsignal_q` <= `nsignal` on the clock edge leaving EXEC or ORIEX. It holds its value in every other state.
- Wait counter applies to FETCH, MEMRD and MEMWR:
  - Cleared on entry to each of these states.
  - Increments each cycle the state waits with `mem_ready` = 0.
  - When it would reach WAIT_LIMIT, pulse `mem_timeout` and abort:
    - FETCH re-enters FETCH (retry) with the counter cleared; no pc_write or ir_write.
    - MEMRD / MEMWR go to FETCH; no register or memory write is committed.

## Timing
- Reset, asynchronous: state = FETCH, `nsignal_q` = 0, wait counter = 0. While `rst_n` = 0, every write strobe (pc_write, pc_write_cond, ir_write, reg_write, mem_write), `illegal` and `mem_timeout` is forced to 0.
- Reset asserted mid-instruction abandons the instruction with no further writes. The first cycle after release is FETCH.
- Latency with zero wait states:
  - beq, jrsal, baln: 3 cycles
  - R-type, sw, ori: 4 cycles
  - lw: 5 cycles
- Each wait cycle adds 1 cycle. `mem_ready` is sampled in the same cycle as mem_read / mem_write.
- If `mem_ready` and the timeout limit coincide, `mem_ready` wins.
- JRSAL with rs = $31: PC takes the old $31 value (A was latched in DECODE). $31 then receives the link value.
- `illegal` and `mem_timeout` are single-cycle pulses, asserted in the cycle that makes the transition.

## Structure
- Package `mc_ctrl_pkg`: opcode constants, the state enum (4-bit), and the encodings for alu_src_b, alu_op, pc_source, reg_dst and mem_to_reg.
- No sub-module. One state register, one wait counter and one flag register, with combinational next-state and output decode.

## Test plan
- lw with `mem_ready` held at 1 → FETCH, DECODE, MEMADDR, MEMRD, MEMWB, FETCH. reg_write with mem_to_reg=01 in cycle 5 only.
- sw with `mem_ready` low for 3 cycles in MEMWR → mem_write held for 4 cycles; 7 cycles in total.
- R-type with `nsignal`=1 in EXEC, then baln → `nsignal_q`=1; in BALN, pc_write=1, reg_write=1, reg_dst=10. Repeat with `nsignal`=0 → no writes in BALN.
- Opcode 111111 → `illegal` pulses in DECODE; next state FETCH; no strobes asserted.
- WAIT_LIMIT=4 with `mem_ready` stuck at 0 in MEMRD → `mem_timeout` after 4 cycles, return to FETCH, no reg_write. Same condition in FETCH → FETCH retries with no pc_write.
- `rst_n` pulled low during MEMWB → reg_write is 0 immediately; after release state_o = FETCH and `nsignal_q` = 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state
// encoding and the datapath select encodings.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRSAL = 6'b010001;
  localparam logic [5:0] OP_BALN  = 6'b011001;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BEQ     = 4'd8,
    S_ORIEX   = 4'd9,
    S_ORIWB   = 4'd10,
    S_JRSAL   = 4'd11,
    S_BALN    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SL2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_RS     = 2'b10
  } pc_source_t;

  typedef enum logic [1:0] {
    RDST_RT = 2'b00,
    RDST_RD = 2'b01,
    RDST_RA = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } mem_to_reg_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/status inputs and control strobes.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       nsignal;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       nsignal_q;
  logic       illegal;
  logic       mem_timeout;
  logic [3:0] state_o;

  modport master (
    input  opcode, nsignal, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst,
           mem_to_reg, nsignal_q, illegal, mem_timeout, state_o
  );

  modport slave (
    output opcode, nsignal, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst,
           mem_to_reg, nsignal_q, illegal, mem_timeout, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences each instruction over 3-5
// states, waits on memory with a bounded timeout and owns the N flag.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned WAIT_LIMIT    = 16,
  parameter int unsigned WAIT_W        = $clog2(WAIT_LIMIT + 1)
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_control_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_nsignal;

  logic        w_ready;
  logic        w_mem_state;
  logic        w_timeout;
  logic        w_pc_write;
  logic        w_pc_write_cond;
  logic        w_iord;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_reg_write;
  logic        w_alu_src_a;
  alu_src_b_t  w_alu_src_b;
  alu_op_t     w_alu_op;
  pc_source_t  w_pc_source;
  reg_dst_t    w_reg_dst;
  mem_to_reg_t w_mem_to_reg;
  logic        w_illegal;

  assign w_ready     = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_ready;
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  // Ready takes priority: a timeout only fires on a cycle that is still waiting.
  assign w_timeout   = w_mem_state && !w_ready && (r_wait_cnt == WAIT_LAST);
  // Any exit (including a FETCH retry) restarts the count from zero.
  assign w_wait_next = (w_mem_state && !w_ready && !w_timeout) ?
                       r_wait_cnt + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_nsignal  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if ((r_state == S_EXEC) || (r_state == S_ORIEX))
        r_nsignal <= bus.nsignal;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_B;
    w_alu_op        = ALUOP_ADD;
    w_pc_source     = PCSRC_ALU;
    w_reg_dst       = RDST_RT;
    w_mem_to_reg    = M2R_ALUOUT;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (w_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMM_SL2;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADDR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_ORI:       w_next = S_ORIEX;
          OP_JRSAL:     w_next = S_JRSAL;
          OP_BALN:      w_next = S_BALN;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (w_ready)        w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = M2R_MDR;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (w_ready || w_timeout) w_next = S_FETCH;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_RWB;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = RDST_RD;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALUOP_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
        w_next          = S_FETCH;
      end
      S_ORIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALUOP_OR;
        w_next      = S_ORIWB;
      end
      S_ORIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JRSAL: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCSRC_RS;
        w_reg_write  = 1'b1;
        w_reg_dst    = RDST_RA;
        w_mem_to_reg = M2R_PC;
        w_next       = S_FETCH;
      end
      S_BALN: begin
        w_pc_write   = r_nsignal;
        w_reg_write  = r_nsignal;
        w_pc_source  = PCSRC_ALUOUT;
        w_reg_dst    = RDST_RA;
        w_mem_to_reg = M2R_PC;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write strobes and pulses are held low for the whole reset assertion.
  assign bus.pc_write      = rst_n & w_pc_write;
  assign bus.pc_write_cond = rst_n & w_pc_write_cond;
  assign bus.mem_write     = rst_n & w_mem_write;
  assign bus.ir_write      = rst_n & w_ir_write;
  assign bus.reg_write     = rst_n & w_reg_write;
  assign bus.illegal       = rst_n & w_illegal;
  assign bus.mem_timeout   = rst_n & w_timeout;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_source     = w_pc_source;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.nsignal_q     = r_nsignal;
  assign bus.state_o       = r_state;

endmodule
